unpacked_array_packer: RTL and testbench



---
 rtl/unpacked_array_packer.sv | 200 ++++++++++++++++++++
 tb/tb_unpacked_array_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpacked_array_packer.sv
// -----------------------------------------------------------------------------
// unpacked_array_packer
//
// Collects a stream of DW-bit words, one per accepted in_valid/in_ready
// handshake, into a DEPTH-entry unpacked array. The array is then presented
// flattened as one packed DW*DEPTH vector behind an out_valid/out_ready
// handshake. A group closes when it fills the last element or when the
// accepted word carries in_last. Elements that a short group leaves unwritten
// read as 0.
//
// Optional feature (compile-time macro):
//   UNPACKED_ARRAY_PACKER_DESCEND_EN
//     undefined : the first word of a group is element 0 (out_data[DW-1:0])
//     defined   : the first word is element DEPTH-1 (top slice) and the
//                 write index counts down from there
//
// Parameters:
//   DW     word width in bits (>= 1)
//   DEPTH  array entries (>= 2)
//   CW     width of out_count, $clog2(DEPTH+1) (derived, not overridable)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   producer has a word
//   in_ready   out  block accepts a word this cycle
//   in_data    in   word to store
//   in_last    in   accepted word closes the group early
//   out_valid  out  packed array available
//   out_ready  in   consumer takes the packed array
//   out_data   out  packed array, element i at [i*DW +: DW]
//   out_count  out  number of valid elements in out_data (1..DEPTH)
// -----------------------------------------------------------------------------
module unpacked_array_packer #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW*DEPTH-1:0] out_data,
    output logic [CW-1:0]       out_count
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    state_t         r_state;
    logic [CW-1:0]  r_wptr;
    logic [CW-1:0]  r_count;
    logic [DW-1:0]  r_arr [0:DEPTH-1];

    state_t         w_state_nxt;
    logic [CW-1:0]  w_wptr_nxt;
    logic [CW-1:0]  w_count_nxt;
    logic           w_accept;
    logic           w_wr_en;
    logic [CW-1:0]  w_wr_idx;
    logic           w_clear;
    logic [DW*DEPTH-1:0] w_flat;

    // Physical slot for a logical position: ascending mode stores the n-th
    // word at element n, descending mode mirrors it from the top.
    function automatic logic [CW-1:0] slot_of(input logic [CW-1:0] pos);
`ifdef UNPACKED_ARRAY_PACKER_DESCEND_EN
        return LAST_IDX - pos;
`else
        return pos;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and handshake logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = slot_of(r_wptr);
        w_clear     = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        unique case (r_state)
            S_FILL: begin
                in_ready = ~rst;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                // A new group may start in the same cycle the old one drains.
                in_ready  = out_ready & ~rst;
            end
            default: ;
        endcase

        w_accept = in_valid & in_ready;

        unique case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_wr_en    = 1'b1;
                    w_wptr_nxt = r_wptr + CW'(1);
                    if (r_wptr == LAST_IDX || in_last) begin
                        w_state_nxt = S_HOLD;
                        w_count_nxt = r_wptr + CW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_clear = 1'b1;
                    if (w_accept) begin
                        // Drained group is replaced by a fresh one whose
                        // first word lands in the first slot.
                        w_wr_en    = 1'b1;
                        w_wr_idx   = slot_of('0);
                        w_wptr_nxt = CW'(1);
                        if (in_last) begin
                            w_state_nxt = S_HOLD;
                            w_count_nxt = CW'(1);
                        end else begin
                            w_state_nxt = S_FILL;
                            w_count_nxt = '0;
                        end
                    end else begin
                        w_wptr_nxt  = '0;
                        w_count_nxt = '0;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, pointer and count registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_FILL;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= w_wptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Element storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is reset deliberately: unwritten elements of a short
        // group must read as 0, and a reset must discard stale words. This
        // keeps it in flops rather than a RAM macro.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_arr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en && w_wr_idx == CW'(i)) begin
                    r_arr[i] <= in_data;
                end else if (w_clear) begin
                    r_arr[i] <= '0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output flattening (combinational, zeroed outside HOLD)
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_flat[i*DW +: DW] = r_arr[i];
        end
    end

    assign out_data  = (r_state == S_HOLD) ? w_flat  : '0;
    assign out_count = (r_state == S_HOLD) ? r_count : '0;

endmodule

// File: tb/tb_unpacked_array_packer.sv
// -----------------------------------------------------------------------------
// tb_unpacked_array_packer
//
// Directed self-checking bench for unpacked_array_packer with DW=32, DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected packed vectors follow the build's element ordering
// (UNPACKED_ARRAY_PACKER_DESCEND_EN).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unpacked_array_packer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef UNPACKED_ARRAY_PACKER_DESCEND_EN
    localparam logic [127:0] EXP_DCBA  = 128'h0000000d_0000000c_0000000b_0000000a;
    localparam logic [127:0] EXP_SHORT = 128'h00000011_00000022_00000000_00000000;
    localparam logic [127:0] EXP_G1    = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] EXP_G2    = 128'h00000005_00000006_00000007_00000008;
    localparam logic [127:0] EXP_G3    = 128'h00000009_0000000a_0000000b_0000000c;
    localparam logic [127:0] EXP_ONE5  = 128'h00000005_00000000_00000000_00000000;
`else
    localparam logic [127:0] EXP_DCBA  = 128'h0000000a_0000000b_0000000c_0000000d;
    localparam logic [127:0] EXP_SHORT = 128'h00000000_00000000_00000022_00000011;
    localparam logic [127:0] EXP_G1    = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] EXP_G2    = 128'h00000008_00000007_00000006_00000005;
    localparam logic [127:0] EXP_G3    = 128'h0000000c_0000000b_0000000a_00000009;
    localparam logic [127:0] EXP_ONE5  = 128'h00000000_00000000_00000000_00000005;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [DW*DEPTH-1:0] out_data;
    logic [CW-1:0]       out_count;

    int n_checks = 0;
    int n_fail   = 0;

    unpacked_array_packer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one word and hold it until accepted (bounded wait).
    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %h never accepted", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Release the current HOLD group with a one-cycle out_ready pulse.
    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_count !== '0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_group();
        send(32'hd, 1'b0);
        send(32'hc, 1'b0);
        send(32'hb, 1'b0);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        send(32'ha, 1'b0);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== EXP_DCBA) begin n_fail++; $display("FAIL full_data: got %h want %h", out_data, EXP_DCBA); end
        n_checks++;
        if (out_count !== CW'(4)) begin n_fail++; $display("FAIL full_count: got %0d want 4", out_count); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_hold: got %b want 0", in_ready); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== EXP_DCBA) begin
            n_fail++; $display("FAIL full_stable: valid %b data %h want 1 %h", out_valid, out_data, EXP_DCBA);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready_drain: got %b want 1", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_count !== '0) begin
            n_fail++; $display("FAIL full_drained: valid %b count %0d want 0 0", out_valid, out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_short_group();
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== EXP_SHORT) begin n_fail++; $display("FAIL short_data: got %h want %h", out_data, EXP_SHORT); end
        n_checks++;
        if (out_count !== CW'(2)) begin n_fail++; $display("FAIL short_count: got %0d want 2", out_count); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            in_data = DW'(k);
            exp_v = (k == 5 || k == 9);
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready); end
            n_checks++;
            if (out_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, out_valid, exp_v); end
            if (k == 5) begin
                n_checks++;
                if (out_data !== EXP_G1) begin n_fail++; $display("FAIL b2b_group1: got %h want %h", out_data, EXP_G1); end
            end
            if (k == 9) begin
                n_checks++;
                if (out_data !== EXP_G2) begin n_fail++; $display("FAIL b2b_group2: got %h want %h", out_data, EXP_G2); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== EXP_G3 || out_count !== CW'(4)) begin
            n_fail++; $display("FAIL b2b_group3: valid %b data %h count %0d want 1 %h 4", out_valid, out_data, out_count, EXP_G3);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_group();
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: in_ready %b out_valid %b want 0 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send(32'hd, 1'b0);
        send(32'hc, 1'b0);
        send(32'hb, 1'b0);
        send(32'ha, 1'b0);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== EXP_DCBA || out_count !== CW'(4)) begin
            n_fail++; $display("FAIL midrst_group: valid %b data %h count %0d want 1 %h 4", out_valid, out_data, out_count, EXP_DCBA);
        end
        @(posedge clk); #1;
    endtask

    // Enters with a full group in HOLD; a single-word group arrives in the
    // same cycle the held group drains.
    task automatic test_drain_accept();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        in_last   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drainacc_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drainacc_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== EXP_ONE5) begin n_fail++; $display("FAIL drainacc_data: got %h want %h", out_data, EXP_ONE5); end
        n_checks++;
        if (out_count !== CW'(1)) begin n_fail++; $display("FAIL drainacc_count: got %0d want 1", out_count); end
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_short_group();
        test_back_to_back();
        test_reset_mid_group();
        test_drain_accept();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
